cla_adder_pipe: RTL and testbench
=================================

CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 by the package constant CLA_WIDTH.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  operand beat offered.
REQ-005 in_ready  out  1  stage 1 can accept a beat this cycle.
REQ-006 data_a  in  32  operand A.
REQ-007 data_b  in  32  operand B.
REQ-008 carry_in  in  1  carry into bit 0.
REQ-009 sub  in  1  subtract request; present only when CLA_SUB_EN is defined.
REQ-010 out_valid  out  1  result beat held.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 sum  out  32  result bits.
REQ-013 carry_out  out  1  carry out of bit 31.
REQ-014 overflow  out  1  two's-complement overflow.

Function
REQ-015 The block SHALL be a two-stage valid/ready pipeline; a beat transfers on any edge where valid and ready are both high.
REQ-016 Stage 1 SHALL register the per-bit propagate p[i] = a[i] XOR b'[i], the per-bit generate g[i] = a[i] AND b'[i], the four 8-bit group G/P pairs, and the effective carry-in cin'; b' and cin' are defined in REQ-022.
REQ-017 Stage 2 SHALL register c8, c16, c24 and c32 from the lookahead equations over the group G/P pairs, intra-group carries, sum[i] = p[i] XOR c[i], carry_out = c32, and overflow = c31 XOR c32.
REQ-018 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when out_ready stays high; throughput SHALL be 1 beat per cycle.
REQ-019 in_ready SHALL be high when stage 1 is empty, or when stage 1 moves into stage 2 this cycle; stage 2 SHALL accept when it is empty or out_ready is high.
REQ-020 While out_valid is high and out_ready is low, sum, carry_out and overflow SHALL hold stable, and no beat SHALL be dropped or duplicated.
REQ-021 Arithmetic SHALL wrap modulo 2^32, with no saturation.
REQ-022 With CLA_SUB_EN defined and sub=1, b' = ~data_b and cin' = 1, and carry_in SHALL be ignored; otherwise b' = data_b and cin' = carry_in.

Reset
REQ-023 While reset is high, both stage-valid flags, out_valid, sum, carry_out and overflow SHALL be 0.
REQ-024 A beat in flight when reset asserts SHALL be discarded.
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 Macro CLA_SUB_EN: defined -> sub port exists and REQ-022 applies; undefined -> sub port absent and the block is add-only.

Structure
REQ-027 Package cla_pkg SHALL hold CLA_WIDTH=32, CLA_GROUP=8, CLA_NGROUPS=4, and the typedefs word_t, grp_t and stage1_t (a packed struct of p, g, group G/P and cin').
REQ-028 One sub-module, cla_group8, SHALL compute the 8-bit group G/P and the intra-group carries; it SHALL be instantiated 4 times.

Verification
REQ-029 a=0x0000_0001, b=0xFFFF_FFFF, cin=0, out_ready=1 -> 2 cycles later sum=0x0000_0000, carry_out=1, overflow=0.
REQ-030 a=0x7FFF_FFFF, b=0x0000_0001 -> sum=0x8000_0000, carry_out=0, overflow=1.
REQ-031 10 back-to-back beats with out_ready=1 -> 10 results in order, one per cycle, in_ready never low.
REQ-032 out_ready held low for 5 cycles while 3 beats are offered -> in_ready falls after 2 beats accepted, output holds the first result stable, and all 3 results emerge in order once out_ready rises.
REQ-033 Reset asserted mid-stream with 2 beats in flight -> out_valid=0 immediately, and no stale result appears after reset deasserts.
REQ-034 With CLA_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, carry_out=0, overflow=0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the two-stage 32-bit carry-lookahead adder.
// Holds the stage-1 payload layout and the group-level lookahead equations.
package cla_pkg;

  localparam int CLA_WIDTH   = 32;
  localparam int CLA_GROUP   = 8;
  localparam int CLA_NGROUPS = 4;

  typedef logic [CLA_WIDTH-1:0]   word_t;
  typedef logic [CLA_NGROUPS-1:0] grp_t;

  typedef struct packed {
    word_t p;
    word_t g;
    grp_t  grp_g;
    grp_t  grp_p;
    logic  cin;
  } stage1_t;

  // Flattened lookahead across the four groups; c[k] is the carry into bit 8*k.
  function automatic logic [CLA_NGROUPS:0] group_carries(input grp_t gg,
                                                          input grp_t gp,
                                                          input logic cin);
    logic [CLA_NGROUPS:0] c;
    c[0] = cin;
    c[1] = gg[0] | (gp[0] & cin);
    c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
         | (gp[2] & gp[1] & gp[0] & cin);
    c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0])
         | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_group8.sv
// One 8-bit lookahead group: group generate/propagate from the incoming operand bits,
// and intra-group carries from the registered bits once the group carry-in is known.
module cla_group8
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] p_gp,
  input  logic [CLA_GROUP-1:0] g_gp,
  output logic                 grp_g,
  output logic                 grp_p,
  input  logic [CLA_GROUP-1:0] p_c,
  input  logic [CLA_GROUP-1:0] g_c,
  input  logic                 c_in,
  output logic [CLA_GROUP-1:0] carry
);

  always_comb begin
    grp_p = &p_gp;
    grp_g = g_gp[0];
    for (int i = 1; i < CLA_GROUP; i++) begin
      grp_g = g_gp[i] | (p_gp[i] & grp_g);
    end
  end

  // carry[i] is the carry into bit i of this group.
  always_comb begin
    carry    = '0;
    carry[0] = c_in;
    for (int i = 1; i < CLA_GROUP; i++) begin
      carry[i] = g_c[i-1] | (p_c[i-1] & carry[i-1]);
    end
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage valid/ready 32-bit carry-lookahead adder with two's-complement overflow.
// Optional macro CLA_SUB_EN adds the sub port (a - b via inverted b and forced carry-in).
module cla_adder_pipe
  import cla_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  word_t data_a,
  input  word_t data_b,
  input  logic  carry_in,
`ifdef CLA_SUB_EN
  input  logic  sub,
`endif
  output logic  out_valid,
  input  logic  out_ready,
  output word_t sum,
  output logic  carry_out,
  output logic  overflow
);

  word_t   b_eff_p0;
  logic    cin_p0;
  word_t   p_p0;
  word_t   g_p0;
  grp_t    grp_g_p0;
  grp_t    grp_p_p0;

  stage1_t s1_p1;
  logic    vld_p1;
  logic    [CLA_NGROUPS:0] gc_p1;
  word_t   c_p1;

  word_t   sum_p2;
  logic    cout_p2;
  logic    ovf_p2;
  logic    vld_p2;

  logic    s2_ready;

`ifdef CLA_SUB_EN
  // Subtraction ignores carry_in: a + ~b + 1.
  assign b_eff_p0 = sub ? ~data_b : data_b;
  assign cin_p0   = sub | carry_in;
`else
  assign b_eff_p0 = data_b;
  assign cin_p0   = carry_in;
`endif

  assign p_p0 = data_a ^ b_eff_p0;
  assign g_p0 = data_a & b_eff_p0;

  assign s2_ready = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_ready;

  assign gc_p1 = group_carries(s1_p1.grp_g, s1_p1.grp_p, s1_p1.cin);

  for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_grp
    cla_group8 u_grp (
      .p_gp  (p_p0[k*CLA_GROUP +: CLA_GROUP]),
      .g_gp  (g_p0[k*CLA_GROUP +: CLA_GROUP]),
      .grp_g (grp_g_p0[k]),
      .grp_p (grp_p_p0[k]),
      .p_c   (s1_p1.p[k*CLA_GROUP +: CLA_GROUP]),
      .g_c   (s1_p1.g[k*CLA_GROUP +: CLA_GROUP]),
      .c_in  (gc_p1[k]),
      .carry (c_p1[k*CLA_GROUP +: CLA_GROUP])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (s2_ready) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: per-bit P/G, group P/G, effective carry-in ----
  always_ff @(posedge clock) begin
    if (in_valid && in_ready) begin
      s1_p1 <= '{p: p_p0, g: g_p0, grp_g: grp_g_p0, grp_p: grp_p_p0, cin: cin_p0};
    end
  end

  // ---- stage 2: lookahead carries, sum, carry-out, overflow ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
    end else if (s2_ready && vld_p1) begin
      sum_p2  <= s1_p1.p ^ c_p1;
      cout_p2 <= gc_p1[CLA_NGROUPS];
      ovf_p2  <= c_p1[CLA_WIDTH-1] ^ gc_p1[CLA_NGROUPS];
    end
  end

  assign out_valid = vld_p2;
  assign sum       = sum_p2;
  assign carry_out = cout_p2;
  assign overflow  = ovf_p2;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: scoreboard of expected results pushed on input
// handshakes and popped on output handshakes, plus latency, stall and reset checks.
module tb_cla_adder_pipe;
  import cla_pkg::*;

  typedef struct packed {
    word_t s;
    logic  c;
    logic  v;
  } exp_t;

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b1;
  logic  carry_in = 1'b0;
  logic  sub_r = 1'b0;
  word_t data_a = '0;
  word_t data_b = '0;
  logic  in_ready;
  logic  out_valid;
  word_t sum;
  logic  carry_out;
  logic  overflow;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    n_out = 0;

  always #5 clock = ~clock;

  cla_adder_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .carry_in  (carry_in),
`ifdef CLA_SUB_EN
    .sub       (sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  function automatic exp_t model(input word_t a, input word_t b, input logic ci, input logic sb_in);
    word_t       bb;
    logic        c0;
    logic [32:0] t;
    exp_t        e;
    bb  = sb_in ? ~b : b;
    c0  = sb_in ? 1'b1 : ci;
    t   = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
    e.s = t[31:0];
    e.c = t[32];
    e.v = (a[31] == bb[31]) && (t[31] != a[31]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: handshakes sampled on the falling edge see the values the next rising edge will use.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back(model(data_a, data_b, carry_in, sub_r));
      if (out_valid && out_ready) begin
        n_out++;
        check("out_has_expect", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_sum", sum, e.s);
          check("sb_cout", carry_out, e.c);
          check("sb_ovf", overflow, e.v);
        end
      end
    end
  end

  task automatic send(input word_t a, input word_t b, input logic ci, input logic sb_in,
                      output int waits);
    bit acc;
    acc      = 1'b0;
    waits    = 0;
    data_a   = a;
    data_b   = b;
    carry_in = ci;
    sub_r    = sb_in;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clock);
      waits++;
      if (in_ready) acc = 1'b1;
    end
    check("accept_in_time", 64'(acc), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    sub_r    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    w;
    int    n0;
    bit    acc;
    word_t held;

    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);
    @(posedge clock);
    #1;

    // 1 + 0xFFFFFFFF: latency and wrap to zero
    data_a   = 32'h0000_0001;
    data_b   = 32'hFFFF_FFFF;
    carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("lat_cycle1_valid", out_valid, 0);
    @(posedge clock);
    #1;
    check("lat_cycle2_valid", out_valid, 1);
    check("wrap_sum", sum, 32'h0000_0000);
    check("wrap_cout", carry_out, 1);
    check("wrap_ovf", overflow, 0);

    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, w);
    @(posedge clock);
    #1;
    check("posovf_sum", sum, 32'h8000_0000);
    check("posovf_cout", carry_out, 0);
    check("posovf_ovf", overflow, 1);

    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, w);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, w);
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, w);
    repeat (3) @(posedge clock);
    #1;

    // ten back-to-back beats
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, w);
      check("b2b_ready_first_try", w, 1);
    end
    repeat (3) @(posedge clock);
    #1;
    check("b2b_result_count", n_out - n0, 10);

    // backpressure: three beats offered with out_ready low
    out_ready = 1'b0;
    send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, w);
    send(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0, w);
    data_a   = 32'hDEAD_BEEF;
    data_b   = 32'h1111_1111;
    carry_in = 1'b0;
    in_valid = 1'b1;
    @(negedge clock);
    held = sum;
    check("stall_in_ready", in_ready, 0);
    check("stall_first_result", sum, (sb.size() != 0) ? sb[0].s : ~sum);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_sum_stable", sum, held);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clock);
      if (in_ready) acc = 1'b1;
    end
    check("stall_third_accept", 64'(acc), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("stall_drained", sb.size(), 0);

    // reset with two beats in flight
    out_ready = 1'b0;
    send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, w);
    send(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, w);
    check("inflight_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", carry_out, 0);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_midrst", in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("no_stale_out", out_valid, 0);
    end
    @(posedge clock);
    #1;

`ifdef CLA_SUB_EN
    send(32'd5, 32'd7, 1'b0, 1'b1, w);
    @(posedge clock);
    #1;
    check("sub_sum", sum, 32'hFFFF_FFFE);
    check("sub_cout", carry_out, 0);
    check("sub_ovf", overflow, 0);
    send(32'd5, 32'd7, 1'b1, 1'b1, w);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, w);
`endif

    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, w);
    repeat (4) @(posedge clock);
    #1;
    check("final_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
